// File: rtl/core_ifetch_if.sv
// Fetch-unit bundle: instruction memory read channel,
// decode-side handshake, and branch redirect inputs.
interface core_ifetch_if;
  logic        IMEM_ARVALID;
  logic        IMEM_ARREADY;
  logic [31:0] IMEM_ARADDR;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_INSTRUCTION;
  logic [31:0] IF_PC;
  logic        C_REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IF_EXC_MISALIGNED;

  modport master (
    output IMEM_ARVALID, IMEM_ARADDR,
    input  IMEM_ARREADY, IMEM_RVALID, IMEM_RDATA,
    output IF_VALID, IF_INSTRUCTION, IF_PC,
    input  IF_READY,
    input  C_REDIRECT, REDIRECT_PC,
    output IF_EXC_MISALIGNED
  );

  modport slave (
    input  IMEM_ARVALID, IMEM_ARADDR,
    output IMEM_ARREADY, IMEM_RVALID, IMEM_RDATA,
    input  IF_VALID, IF_INSTRUCTION, IF_PC,
    output IF_READY,
    output C_REDIRECT, REDIRECT_PC,
    input  IF_EXC_MISALIGNED
  );
endinterface

// File: rtl/core_ifetch.sv
// Single-outstanding instruction fetch stage with redirect/drop handling.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module core_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic           CLK,
  input logic           RST,
  core_ifetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc,  w_pc;
  logic [31:0] r_ins, w_ins;
  logic [31:0] r_ipc, w_ipc;
  logic        r_vld, w_vld;
  logic        r_drop, w_drop;
  logic        r_exc, w_exc;
  logic [31:0] w_tgt;
  logic        w_mis;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign w_mis = |bus.REDIRECT_PC[1:0];
  assign w_tgt = bus.REDIRECT_PC;
`else
  assign w_mis = 1'b0;
  assign w_tgt = bus.REDIRECT_PC & 32'hFFFF_FFFC;
`endif

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_ins   = r_ins;
    w_ipc   = r_ipc;
    w_vld   = r_vld;
    w_drop  = r_drop;
    w_exc   = r_exc;
    unique case (r_state)
      S_IDLE: w_state = S_REQ;
      S_REQ: begin
        if (bus.IMEM_ARREADY)
          w_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.IMEM_RVALID) begin
          if (r_drop) begin
            w_drop  = 1'b0;
            w_state = S_REQ;
          end else begin
            w_ins   = bus.IMEM_RDATA;
            w_ipc   = r_pc;
            w_vld   = 1'b1;
            w_pc    = r_pc + 32'd4;
            w_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.IF_READY) begin
          w_vld   = 1'b0;
          w_state = S_REQ;
        end
      end
      S_FAULT: ;
      default: w_state = S_IDLE;
    endcase
    // Redirect overrides whatever the per-state logic decided.
    if (bus.C_REDIRECT && r_state != S_FAULT) begin
      w_vld = 1'b0;
      w_ins = r_ins;
      w_ipc = r_ipc;
      w_pc  = r_pc;
      if (w_mis) begin
        w_exc   = 1'b1;
        w_ipc   = bus.REDIRECT_PC;
        w_state = S_FAULT;
      end else begin
        w_pc = w_tgt;
        unique case (r_state)
          S_REQ: begin
            if (bus.IMEM_ARREADY) begin
              w_drop  = 1'b1;
              w_state = S_WAIT;
            end else begin
              w_state = S_REQ;
            end
          end
          S_WAIT: begin
            if (bus.IMEM_RVALID) begin
              w_drop  = 1'b0;
              w_state = S_REQ;
            end else begin
              w_drop  = 1'b1;
              w_state = S_WAIT;
            end
          end
          default: w_state = S_REQ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_VECTOR;
      r_ins   <= 32'h0;
      r_ipc   <= 32'h0;
      r_vld   <= 1'b0;
      r_drop  <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_ins   <= w_ins;
      r_ipc   <= w_ipc;
      r_vld   <= w_vld;
      r_drop  <= w_drop;
      r_exc   <= w_exc;
    end
  end

  assign bus.IMEM_ARVALID      = (r_state == S_REQ);
  assign bus.IMEM_ARADDR       = r_pc;
  assign bus.IF_VALID          = r_vld;
  assign bus.IF_INSTRUCTION    = r_ins;
  assign bus.IF_PC             = r_ipc;
  assign bus.IF_EXC_MISALIGNED = r_exc;

endmodule

// File: tb/tb_core_ifetch.sv
// Directed bench for core_ifetch: fetch rhythm, stall, redirects,
// PC wrap from a high reset vector, misaligned target, reset abandon.
module tb_core_ifetch;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  core_ifetch_if b0 ();
  core_ifetch_if b1 ();

  core_ifetch u0 (
    .CLK(CLK),
    .RST(RST),
    .bus(b0)
  );

  core_ifetch #(
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) u1 (
    .CLK(CLK),
    .RST(RST),
    .bus(b1)
  );

  int nchk  = 0;
  int npass = 0;

  int          lat  = 0;
  bit          pend = 1'b0;
  int          cnt  = 0;
  logic [31:0] paddr = 32'h0;

  bit          p1 = 1'b0;
  logic [31:0] a1 = 32'h0;

  // Memory for u0: response lat cycles after the accepting edge.
  always @(posedge CLK) begin
    if (!RST && b0.IMEM_ARVALID && b0.IMEM_ARREADY) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = b0.IMEM_ARADDR;
    end
  end

  always @(negedge CLK) begin
    b0.IMEM_RVALID = 1'b0;
    b0.IMEM_RDATA  = 32'h0;
    if (pend) begin
      if (cnt == 0) begin
        b0.IMEM_RVALID = 1'b1;
        b0.IMEM_RDATA  = ~paddr;
        pend           = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  // Memory for u1: always answers the cycle after accept.
  always @(posedge CLK) begin
    p1 = !RST && b1.IMEM_ARVALID && b1.IMEM_ARREADY;
    a1 = b1.IMEM_ARADDR;
  end

  always @(negedge CLK) begin
    b1.IMEM_RVALID = p1;
    b1.IMEM_RDATA  = ~a1;
    p1             = 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    RST               = 1'b1;
    b0.IMEM_ARREADY   = 1'b1;
    b0.IF_READY       = 1'b1;
    b0.C_REDIRECT     = 1'b0;
    b0.REDIRECT_PC    = 32'h0;
    b1.IMEM_ARREADY   = 1'b1;
    b1.IF_READY       = 1'b1;
    b1.C_REDIRECT     = 1'b0;
    b1.REDIRECT_PC    = 32'h0;

    repeat (2) tick();
    chk("rst_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("rst_ifvalid", b0.IF_VALID, 32'd0);
    chk("rst_ifpc", b0.IF_PC, 32'h0);
    chk("rst_ins", b0.IF_INSTRUCTION, 32'h0);
    chk("rst_exc", b0.IF_EXC_MISALIGNED, 32'd0);
    chk("rst_araddr", b0.IMEM_ARADDR, 32'h0);
    chk("rst_araddr_hi", b1.IMEM_ARADDR, 32'hFFFF_FFFC);
    RST = 1'b0;

    tick();
    chk("c0_arvalid", b0.IMEM_ARVALID, 32'd1);
    chk("c0_araddr", b0.IMEM_ARADDR, 32'h0);
    chk("hi_arvalid", b1.IMEM_ARVALID, 32'd1);
    chk("hi_araddr0", b1.IMEM_ARADDR, 32'hFFFF_FFFC);
    tick();
    chk("c1_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("c1_ifvalid", b0.IF_VALID, 32'd0);
    tick();
    chk("c2_ifvalid", b0.IF_VALID, 32'd1);
    chk("c2_ifpc", b0.IF_PC, 32'h0);
    chk("c2_ins", b0.IF_INSTRUCTION, 32'hFFFF_FFFF);
    chk("hi_ifpc0", b1.IF_PC, 32'hFFFF_FFFC);
    chk("hi_ins0", b1.IF_INSTRUCTION, 32'h0000_0003);
    tick();
    chk("c3_arvalid", b0.IMEM_ARVALID, 32'd1);
    chk("c3_araddr", b0.IMEM_ARADDR, 32'h4);
    chk("c3_ifvalid", b0.IF_VALID, 32'd0);
    chk("hi_araddr1", b1.IMEM_ARADDR, 32'h0);
    tick();
    lat = 2;
    tick();
    chk("c5_ifpc", b0.IF_PC, 32'h4);
    chk("c5_ins", b0.IF_INSTRUCTION, 32'hFFFF_FFFB);
    chk("hi_ifpc1", b1.IF_PC, 32'h0);
    chk("hi_ins1", b1.IF_INSTRUCTION, 32'hFFFF_FFFF);
    tick();
    chk("c6_araddr", b0.IMEM_ARADDR, 32'h8);

    tick();
    chk("c7_arvalid", b0.IMEM_ARVALID, 32'd0);
    b0.C_REDIRECT  = 1'b1;
    b0.REDIRECT_PC = 32'h100;
    tick();
    b0.C_REDIRECT = 1'b0;
    lat = 0;
    chk("rw_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("rw_pc", b0.IMEM_ARADDR, 32'h100);
    tick();
    chk("drop_ifvalid", b0.IF_VALID, 32'd0);
    chk("drop_arvalid", b0.IMEM_ARVALID, 32'd0);
    tick();
    chk("rw_ifvalid", b0.IF_VALID, 32'd0);
    chk("rw_arvalid2", b0.IMEM_ARVALID, 32'd1);
    chk("rw_araddr", b0.IMEM_ARADDR, 32'h100);
    repeat (2) tick();
    chk("rw_ifv", b0.IF_VALID, 32'd1);
    chk("rw_ifpc", b0.IF_PC, 32'h100);
    chk("rw_ins", b0.IF_INSTRUCTION, 32'hFFFF_FEFF);
    b0.IF_READY = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_ifvalid", b0.IF_VALID, 32'd1);
      chk("st_ifpc", b0.IF_PC, 32'h100);
      chk("st_ins", b0.IF_INSTRUCTION, 32'hFFFF_FEFF);
      chk("st_arvalid", b0.IMEM_ARVALID, 32'd0);
    end

    b0.C_REDIRECT  = 1'b1;
    b0.REDIRECT_PC = 32'h200;
    b0.IF_READY    = 1'b1;
    tick();
    b0.C_REDIRECT = 1'b0;
    chk("rh_ifvalid", b0.IF_VALID, 32'd0);
    chk("rh_arvalid", b0.IMEM_ARVALID, 32'd1);
    chk("rh_araddr", b0.IMEM_ARADDR, 32'h200);
    repeat (2) tick();
    chk("rh_ifpc", b0.IF_PC, 32'h200);
    chk("rh_ins", b0.IF_INSTRUCTION, 32'hFFFF_FDFF);

    b0.C_REDIRECT  = 1'b1;
    b0.REDIRECT_PC = 32'h102;
    tick();
    b0.C_REDIRECT = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_exc", b0.IF_EXC_MISALIGNED, 32'd1);
    chk("mis_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("mis_ifpc", b0.IF_PC, 32'h102);
    chk("mis_ifvalid", b0.IF_VALID, 32'd0);
    b0.C_REDIRECT  = 1'b1;
    b0.REDIRECT_PC = 32'h300;
    tick();
    b0.C_REDIRECT = 1'b0;
    repeat (2) tick();
    chk("flt_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("flt_exc", b0.IF_EXC_MISALIGNED, 32'd1);
`else
    chk("mis_exc", b0.IF_EXC_MISALIGNED, 32'd0);
    chk("mis_arvalid", b0.IMEM_ARVALID, 32'd1);
    chk("mis_araddr", b0.IMEM_ARADDR, 32'h100);
    chk("mis_ifvalid", b0.IF_VALID, 32'd0);
    repeat (2) tick();
    chk("mis_ifv", b0.IF_VALID, 32'd1);
    chk("mis_ifpc", b0.IF_PC, 32'h100);
`endif

    b0.IMEM_ARREADY = 1'b0;
    RST = 1'b1;
    repeat (2) tick();
    chk("r2_exc", b0.IF_EXC_MISALIGNED, 32'd0);
    chk("r2_arvalid", b0.IMEM_ARVALID, 32'd0);
    chk("r2_ifvalid", b0.IF_VALID, 32'd0);
    chk("r2_ifpc", b0.IF_PC, 32'h0);
    chk("r2_ins", b0.IF_INSTRUCTION, 32'h0);
    RST = 1'b0;

    tick();
    chk("nr_araddr0", b0.IMEM_ARADDR, 32'h0);
    b0.C_REDIRECT  = 1'b1;
    b0.REDIRECT_PC = 32'h300;
    tick();
    chk("nr_arvalid", b0.IMEM_ARVALID, 32'd1);
    chk("nr_araddr", b0.IMEM_ARADDR, 32'h300);
    b0.C_REDIRECT   = 1'b0;
    b0.IMEM_ARREADY = 1'b1;
    lat = 1;
    tick();
    chk("ab_arvalid", b0.IMEM_ARVALID, 32'd0);
    RST = 1'b1;
    tick();
    chk("ab_rst_arvalid", b0.IMEM_ARVALID, 32'd0);
    RST = 1'b0;
    lat = 0;
    tick();
    chk("ab_arvalid2", b0.IMEM_ARVALID, 32'd1);
    chk("ab_araddr", b0.IMEM_ARADDR, 32'h0);
    chk("ab_ifvalid", b0.IF_VALID, 32'd0);
    repeat (2) tick();
    chk("ab_ifv", b0.IF_VALID, 32'd1);
    chk("ab_ifpc", b0.IF_PC, 32'h0);
    chk("ab_ins", b0.IF_INSTRUCTION, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
